// File: rtl/lsu_pkg.sv
// Shared types and sizing for the LSU memory sequencer: lane/warp counts,
// FSM state encoding and the latched request record.
package lsu_pkg;

  localparam int NUM_WARPS  = 4;
  localparam int NUM_LANES  = 8;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_t;

  typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_data_t;
  typedef logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] lane_addr_t;

  typedef struct packed {
    logic                 write;
    logic [3:0]           dest;
    logic [NUM_LANES-1:0] mask;
    lane_addr_t           addr;
    lane_data_t           wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_mem_sequencer_if.sv
// Bundle of warp request, memory port and write-back/completion signals
// around the LSU memory sequencer.
interface lsu_mem_sequencer_if;
  import lsu_pkg::*;

  logic [NUM_WARPS-1:0]                req_valid;
  logic [NUM_WARPS-1:0]                req_ready;
  logic [NUM_WARPS-1:0]                req_write;
  logic [NUM_WARPS-1:0][3:0]           req_dest;
  logic [NUM_WARPS-1:0][NUM_LANES-1:0] req_mask;
  lane_addr_t [NUM_WARPS-1:0]          req_addr;
  lane_data_t [NUM_WARPS-1:0]          req_wdata;

  logic                 mem_en;
  logic                 mem_we;
  logic [NUM_LANES-1:0] mem_lane_en;
  lane_addr_t           mem_addr;
  lane_data_t           mem_wdata;
  lane_data_t           mem_rdata;

  logic                 wb_valid;
  logic [1:0]           wb_warp;
  logic [3:0]           wb_dest;
  logic [NUM_LANES-1:0] wb_mask;
  lane_data_t           wb_data;

  logic                 done_valid;
  logic [1:0]           done_warp;
  logic                 busy;

  // The sequencer side: receives requests and read data, drives everything else.
  modport slave (
    input  req_valid, req_write, req_dest, req_mask, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_en, mem_we, mem_lane_en, mem_addr, mem_wdata,
    output wb_valid, wb_warp, wb_dest, wb_mask, wb_data, done_valid, done_warp, busy
  );

  modport master (
    output req_valid, req_write, req_dest, req_mask, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_en, mem_we, mem_lane_en, mem_addr, mem_wdata,
    input  wb_valid, wb_warp, wb_dest, wb_mask, wb_data, done_valid, done_warp, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Four-way round-robin arbiter: grants the first requester at or after ptr,
// wrapping from the highest index back to 0.
module rr_arbiter
  import lsu_pkg::*;
(
  input  logic [NUM_WARPS-1:0] req,
  input  logic [1:0]           ptr,
  output logic [NUM_WARPS-1:0] grant,
  output logic [1:0]           idx,
  output logic                 any
);

  logic [1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      cand = ptr + 2'(k);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Arbitrates warp load/store requests onto the single 8-lane data-memory port,
// waits the fixed memory latency and reports write-back and completion.
module lsu_mem_sequencer
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input logic                clk,
  input logic                reset,
  lsu_mem_sequencer_if.slave bus
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  lsu_state_t state_q, state_d;
  logic [1:0] rr_ptr_q;
  logic [1:0] warp_q;
  lsu_req_t   req_q;
  lsu_req_t   sel_req;
  lane_data_t rdata_q;
  logic [CNT_W-1:0] cnt_q;

  logic [NUM_WARPS-1:0] grant;
  logic [1:0]           grant_idx;
  logic                 grant_any;
  logic                 accept;
  logic                 load_resp;

  rr_arbiter u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_comb begin
    sel_req       = '0;
    sel_req.write = bus.req_write[grant_idx];
    sel_req.dest  = bus.req_dest[grant_idx];
    sel_req.mask  = bus.req_mask[grant_idx];
    sel_req.addr  = bus.req_addr[grant_idx];
    sel_req.wdata = bus.req_wdata[grant_idx];
  end

  // A grant during reset would be lost, so the accept is suppressed while reset is high.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_any && !reset) begin
          accept  = 1'b1;
          state_d = (sel_req.mask == '0) ? RESP : ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      warp_q   <= '0;
      req_q    <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q    <= sel_req;
        warp_q   <= grant_idx;
        rr_ptr_q <= grant_idx + 2'd1;
        rdata_q  <= '0;
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_W'(MEM_LATENCY - 1);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == WAIT && cnt_q == '0) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          rdata_q[i] <= req_q.mask[i] ? bus.mem_rdata[i] : '0;
        end
      end
    end
  end

  // Empty-mask loads have nothing to write back, so they only report completion.
  assign load_resp = (state_q == RESP) && !req_q.write && (req_q.mask != '0);

  always_comb begin
    bus.req_ready   = (state_q == IDLE && !reset) ? grant : '0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_lane_en = '0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_warp     = '0;
    bus.wb_dest     = '0;
    bus.wb_mask     = '0;
    bus.wb_data     = '0;
    bus.done_valid  = 1'b0;
    bus.done_warp   = '0;
    bus.busy        = (state_q != IDLE);
    if (state_q == ISSUE) begin
      bus.mem_en      = 1'b1;
      bus.mem_we      = req_q.write;
      bus.mem_lane_en = req_q.mask;
      bus.mem_addr    = req_q.addr;
      bus.mem_wdata   = req_q.wdata;
    end
    if (state_q == RESP) begin
      bus.done_valid = 1'b1;
      bus.done_warp  = warp_q;
    end
    if (load_resp) begin
      bus.wb_valid = 1'b1;
      bus.wb_warp  = warp_q;
      bus.wb_dest  = req_q.dest;
      bus.wb_mask  = req_q.mask;
      bus.wb_data  = rdata_q;
    end
  end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer: one instance at MEM_LATENCY=1 and one
// at MEM_LATENCY=3, each with a memory model that presents data only in the sample cycle.
module tb_lsu_mem_sequencer;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  logic [15:0] rd_base1 = 16'h0000;
  logic [15:0] rd_base3 = 16'h0000;
  logic        en1_q = 1'b0;
  logic [2:0]  en3_q = 3'b000;

  lsu_mem_sequencer_if bus1();
  lsu_mem_sequencer_if bus3();

  lsu_mem_sequencer #(.MEM_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  lsu_mem_sequencer #(.MEM_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;

  // Memory returns base+lane exactly MEM_LATENCY cycles after mem_en, garbage otherwise.
  always @(posedge clk) begin
    en1_q <= bus1.mem_en;
    en3_q <= {en3_q[1:0], bus3.mem_en};
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      bus1.mem_rdata[i] = en1_q ? rd_base1 + 16'(i) : 16'hDEAD;
      bus3.mem_rdata[i] = en3_q[2] ? rd_base3 + 16'(i) : 16'hDEAD;
    end
  end

  task automatic set_req1(input int w, input logic wr, input logic [3:0] dest,
                          input logic [7:0] mask, input logic [7:0] abase, input logic [15:0] dbase);
    bus1.req_write[w] = wr;
    bus1.req_dest[w]  = dest;
    bus1.req_mask[w]  = mask;
    for (int i = 0; i < NUM_LANES; i++) begin
      bus1.req_addr[w][i]  = abase + 8'(i);
      bus1.req_wdata[w][i] = dbase + 16'(i);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus1.busy !== 1'b0 || bus3.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b/%0b expected 0/0", bus1.busy, bus3.busy); end
    checks++; if (bus1.mem_en !== 1'b0 || bus1.done_valid !== 1'b0 || bus1.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_outputs: got en=%0b done=%0b wb=%0b expected 0", bus1.mem_en, bus1.done_valid, bus1.wb_valid); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus1.req_ready !== 4'b0000 || bus1.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle: got ready=%b busy=%0b expected 0000/0", bus1.req_ready, bus1.busy); end
  endtask

  task automatic test_single_load();
    rd_base1 = 16'hA000;
    set_req1(2, 1'b0, 4'd5, 8'hFF, 8'h10, 16'h0000);
    bus1.req_valid = 4'b0100;
    #1;
    checks++; if (bus1.req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL load_ready: got %b expected 0100", bus1.req_ready); end
    checks++; if (bus1.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL load_en_T: got %0b expected 0", bus1.mem_en); end
    @(negedge clk);
    bus1.req_valid = 4'b0000;
    checks++; if (bus1.mem_en !== 1'b1 || bus1.mem_we !== 1'b0 || bus1.mem_lane_en !== 8'hFF) begin errors++; $display("[TB] FAIL load_issue: got en=%0b we=%0b lanes=%h expected 1/0/ff", bus1.mem_en, bus1.mem_we, bus1.mem_lane_en); end
    checks++; if (bus1.mem_addr[3] !== 8'h13) begin errors++; $display("[TB] FAIL load_addr3: got %h expected 13", bus1.mem_addr[3]); end
    @(negedge clk);
    checks++; if (bus1.mem_en !== 1'b0 || bus1.mem_lane_en !== 8'h00 || bus1.busy !== 1'b1 || bus1.done_valid !== 1'b0) begin errors++; $display("[TB] FAIL load_wait: got en=%0b lanes=%h busy=%0b done=%0b expected 0/00/1/0", bus1.mem_en, bus1.mem_lane_en, bus1.busy, bus1.done_valid); end
    @(negedge clk);
    checks++; if (bus1.wb_valid !== 1'b1 || bus1.done_valid !== 1'b1) begin errors++; $display("[TB] FAIL load_resp: got wb=%0b done=%0b expected 1/1", bus1.wb_valid, bus1.done_valid); end
    checks++; if (bus1.wb_warp !== 2'd2 || bus1.done_warp !== 2'd2 || bus1.wb_dest !== 4'd5 || bus1.wb_mask !== 8'hFF) begin errors++; $display("[TB] FAIL load_wb_meta: got warp=%0d/%0d dest=%0d mask=%h expected 2/2/5/ff", bus1.wb_warp, bus1.done_warp, bus1.wb_dest, bus1.wb_mask); end
    for (int i = 0; i < NUM_LANES; i++) begin
      checks++; if (bus1.wb_data[i] !== 16'hA000 + 16'(i)) begin errors++; $display("[TB] FAIL load_data lane %0d: got %h expected %h", i, bus1.wb_data[i], 16'hA000 + 16'(i)); end
    end
    @(negedge clk);
    checks++; if (bus1.done_valid !== 1'b0 || bus1.wb_valid !== 1'b0 || bus1.wb_data[0] !== 16'h0) begin errors++; $display("[TB] FAIL load_after: got done=%0b wb=%0b data0=%h expected 0/0/0", bus1.done_valid, bus1.wb_valid, bus1.wb_data[0]); end
  endtask

  task automatic test_store();
    set_req1(1, 1'b1, 4'd3, 8'h0F, 8'h20, 16'h0000);
    bus1.req_valid = 4'b0010;
    #1;
    checks++; if (bus1.req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL store_ready: got %b expected 0010", bus1.req_ready); end
    @(negedge clk);
    bus1.req_valid = 4'b0000;
    checks++; if (bus1.mem_en !== 1'b1 || bus1.mem_we !== 1'b1 || bus1.mem_lane_en !== 8'h0F) begin errors++; $display("[TB] FAIL store_issue: got en=%0b we=%0b lanes=%h expected 1/1/0f", bus1.mem_en, bus1.mem_we, bus1.mem_lane_en); end
    checks++; if (bus1.mem_wdata[3] !== 16'd3 || bus1.mem_addr[2] !== 8'h22) begin errors++; $display("[TB] FAIL store_payload: got wdata3=%h addr2=%h expected 0003/22", bus1.mem_wdata[3], bus1.mem_addr[2]); end
    @(negedge clk);
    checks++; if (bus1.mem_we !== 1'b0 || bus1.wb_valid !== 1'b0 || bus1.done_valid !== 1'b0) begin errors++; $display("[TB] FAIL store_wait: got we=%0b wb=%0b done=%0b expected 0/0/0", bus1.mem_we, bus1.wb_valid, bus1.done_valid); end
    @(negedge clk);
    checks++; if (bus1.done_valid !== 1'b1 || bus1.done_warp !== 2'd1) begin errors++; $display("[TB] FAIL store_done: got done=%0b warp=%0d expected 1/1", bus1.done_valid, bus1.done_warp); end
    checks++; if (bus1.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL store_no_wb: got %0b expected 0", bus1.wb_valid); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int order [5] = '{0, 1, 2, 3, 0};
    int ng = 0;
    int nd = 0;
    rd_base1 = 16'h5000;
    for (int w = 0; w < NUM_WARPS; w++) set_req1(w, 1'b0, 4'(w), 8'hFF, 8'(8'h40 + 8'(w * 8)), 16'h0000);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    bus1.req_valid = 4'b1111;
    reset = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (bus1.req_ready !== 4'b0000) begin
        checks++;
        if (ng >= 5 || bus1.req_ready !== 4'(1 << order[ng]) || cyc != ng * 4) begin
          errors++; $display("[TB] FAIL b2b_grant #%0d: got ready=%b cycle=%0d expected %b at cycle %0d", ng, bus1.req_ready, cyc, (ng < 5) ? 4'(1 << order[ng]) : 4'b0, ng * 4);
        end
        ng++;
      end
      if (bus1.done_valid === 1'b1) begin
        checks++;
        if (nd >= 5 || int'(bus1.done_warp) != order[nd] || cyc != nd * 4 + 3) begin
          errors++; $display("[TB] FAIL b2b_done #%0d: got warp=%0d cycle=%0d expected warp %0d at cycle %0d", nd, bus1.done_warp, cyc, (nd < 5) ? order[nd] : 0, nd * 4 + 3);
        end
        nd++;
      end
      @(negedge clk);
    end
    bus1.req_valid = 4'b0000;
    checks++; if (ng != 5) begin errors++; $display("[TB] FAIL b2b_grant_count: got %0d expected 5", ng); end
    checks++; if (nd != 5) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 5", nd); end
    @(negedge clk);
  endtask

  task automatic test_sparse_mask();
    int done_at = -1;
    rd_base3 = 16'hB000;
    bus3.req_write[0] = 1'b0;
    bus3.req_dest[0]  = 4'd9;
    bus3.req_mask[0]  = 8'h81;
    for (int i = 0; i < NUM_LANES; i++) begin
      bus3.req_addr[0][i]  = 8'h60 + 8'(i);
      bus3.req_wdata[0][i] = 16'h0;
    end
    bus3.req_valid = 4'b0001;
    #1;
    checks++; if (bus3.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL sparse_ready: got %b expected 0001", bus3.req_ready); end
    @(negedge clk);
    bus3.req_valid = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      if (bus3.done_valid === 1'b1 && done_at < 0) begin
        done_at = k;
        checks++; if (bus3.wb_valid !== 1'b1 || bus3.wb_mask !== 8'h81) begin errors++; $display("[TB] FAIL sparse_wb: got wb=%0b mask=%h expected 1/81", bus3.wb_valid, bus3.wb_mask); end
        checks++; if (bus3.wb_data[0] !== 16'hB000 || bus3.wb_data[7] !== 16'hB007) begin errors++; $display("[TB] FAIL sparse_edge_lanes: got %h/%h expected b000/b007", bus3.wb_data[0], bus3.wb_data[7]); end
        for (int i = 1; i <= 6; i++) begin
          checks++; if (bus3.wb_data[i] !== 16'h0) begin errors++; $display("[TB] FAIL sparse_lane %0d: got %h expected 0", i, bus3.wb_data[i]); end
        end
      end
      @(negedge clk);
    end
    checks++; if (done_at != 5) begin errors++; $display("[TB] FAIL sparse_latency: got %0d expected 5", done_at); end
  endtask

  task automatic test_empty_mask();
    set_req1(3, 1'b0, 4'd7, 8'h00, 8'h70, 16'h0000);
    bus1.req_valid = 4'b1000;
    #1;
    checks++; if (bus1.req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL empty_ready: got %b expected 1000", bus1.req_ready); end
    @(negedge clk);
    bus1.req_valid = 4'b0000;
    checks++; if (bus1.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL empty_no_mem: got %0b expected 0", bus1.mem_en); end
    checks++; if (bus1.done_valid !== 1'b1 || bus1.done_warp !== 2'd3 || bus1.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_done: got done=%0b warp=%0d wb=%0b expected 1/3/0", bus1.done_valid, bus1.done_warp, bus1.wb_valid); end
    @(negedge clk);
    checks++; if (bus1.busy !== 1'b0 || bus1.done_valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_after: got busy=%0b done=%0b expected 0/0", bus1.busy, bus1.done_valid); end
  endtask

  task automatic test_reset_mid_access();
    for (int w = 0; w < NUM_WARPS; w++) set_req1(w, 1'b0, 4'(w), 8'hFF, 8'h80, 16'h0000);
    bus1.req_valid = 4'b0010;
    #1;
    checks++; if (bus1.req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 0010", bus1.req_ready); end
    @(negedge clk);
    bus1.req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (bus1.busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_wait: got busy=%0b expected 1", bus1.busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus1.busy !== 1'b0 || bus1.mem_en !== 1'b0 || bus1.done_valid !== 1'b0 || bus1.wb_valid !== 1'b0 || bus1.req_ready !== 4'b0) begin errors++; $display("[TB] FAIL midrst_outputs: got busy=%0b en=%0b done=%0b wb=%0b ready=%b expected all 0", bus1.busy, bus1.mem_en, bus1.done_valid, bus1.wb_valid, bus1.req_ready); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus1.done_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_dropped: got done=%0b expected 0", bus1.done_valid); end
    bus1.req_valid = 4'b1111;
    #1;
    checks++; if (bus1.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_priority: got %b expected 0001", bus1.req_ready); end
    @(negedge clk);
    bus1.req_valid = 4'b0000;
    repeat (4) @(negedge clk);
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_drain: got busy=%0b expected 0", bus1.busy); end
  endtask

  initial begin
    bus1.req_valid = '0; bus1.req_write = '0; bus1.req_dest = '0;
    bus1.req_mask  = '0; bus1.req_addr  = '0; bus1.req_wdata = '0;
    bus3.req_valid = '0; bus3.req_write = '0; bus3.req_dest = '0;
    bus3.req_mask  = '0; bus3.req_addr  = '0; bus3.req_wdata = '0;
    test_reset();
    test_single_load();
    test_store();
    test_back_to_back();
    test_sparse_mask();
    test_empty_mask();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
